// File: rtl/uart_vip_pkg.sv
// rtl/uart_vip_pkg.sv - shared types and constants for the UART VIP transmit frame path
package uart_vip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_frame_state_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'd0,
    BITS_6 = 2'd1,
    BITS_7 = 2'd2,
    BITS_8 = 2'd3
  } uart_bits_e;

  localparam int   BIT_OFFSET = 5;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic [3:0] data_bit_count(input uart_bits_e bits);
    return {2'b00, bits} + 4'(BIT_OFFSET);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - loadable baud down-counter; tick marks the last clock of a bit period
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // Holds at zero rather than wrapping, so a full-scale divider never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - serialises accepted bytes into start/data/parity/stop UART frames
module uart_tx_frame_ctrl
  import uart_vip_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [1:0]        cfg_bits_i,
  input  logic              cfg_parity_en_i,
  input  logic              cfg_parity_odd_i,
  input  logic              cfg_stop2_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic              abort_i,
  output logic              uart_rx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_frame_state_e state_q, state_d;
  logic              line_q, line_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_more_q, stop_more_d;

  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] data_q;
  uart_bits_e        bits_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic              stop2_q;

  logic              accept;
  logic              tick;
  logic              load;
  logic [DIV_W-1:0]  load_val;
  logic [3:0]        n_bits;
  logic [IDX_W-1:0]  last_idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] data_mask;
  logic              parity_bit;

  assign data_ready_o = (state_q == IDLE) && !rst_i;
  assign accept       = data_ready_o && data_valid_i;

  assign n_bits     = data_bit_count(bits_q);
  assign last_idx   = IDX_W'(n_bits - 4'd1);
  assign idx_nxt    = idx_q + IDX_W'(1);
  assign data_mask  = ~({DATA_W{1'b1}} << n_bits);
  assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk     (sys_clk_i),
    .rst     (rst_i),
    .load    (load),
    .load_val(load_val),
    .en      (state_q != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      line_q      <= IDLE_LEVEL;
      done_q      <= 1'b0;
      idx_q       <= '0;
      stop_more_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      stop_more_q <= stop_more_d;
    end
  end

  // Frame settings are frozen at accept so mid-frame config changes cannot disturb timing.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      data_q    <= '0;
      bits_q    <= BITS_8;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      div_q     <= cfg_div_i;
      data_q    <= data_i;
      bits_q    <= uart_bits_e'(cfg_bits_i);
      par_en_q  <= cfg_parity_en_i;
      par_odd_q <= cfg_parity_odd_i;
      stop2_q   <= cfg_stop2_i;
    end
  end

  // line_d is the level of the next bit, so the registered line changes with the state.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    done_d      = 1'b0;
    idx_d       = idx_q;
    stop_more_d = stop_more_q;
    load        = 1'b0;
    load_val    = div_q;

    case (state_q)
      IDLE: begin
        line_d = IDLE_LEVEL;
        if (accept) begin
          state_d  = START;
          line_d   = 1'b0;
          load     = 1'b1;
          load_val = cfg_div_i;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          line_d  = data_q[0];
          load    = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (idx_q == last_idx) begin
            if (par_en_q) begin
              state_d = PARITY;
              line_d  = parity_bit;
            end else begin
              state_d     = STOP;
              line_d      = 1'b1;
              stop_more_d = stop2_q;
            end
          end else begin
            idx_d  = idx_nxt;
            line_d = data_q[idx_nxt];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d     = STOP;
          line_d      = 1'b1;
          stop_more_d = stop2_q;
          load        = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_more_q) begin
            stop_more_d = 1'b0;
            load        = 1'b1;
          end else begin
            state_d = IDLE;
            line_d  = IDLE_LEVEL;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = IDLE_LEVEL;
      end
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      line_d      = IDLE_LEVEL;
      done_d      = 1'b0;
      stop_more_d = 1'b0;
      load        = 1'b0;
    end
  end

  assign uart_rx_o    = line_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;

endmodule
